cov_count_reader: RTL and testbench
===================================

Name: cov_count_reader

Overview:
- Readout side of the coverage instrumentation.
- Takes a flattened vector of per-bin toggle counters (net, var and bin-expression counters) from an instrumented module.
- On request, snapshots all counters and streams them one bin per beat over a valid/ready interface.
- Accumulates covered-bin totals for the whole module and for the bin-expression subset, and reports them at end of scan; the testbench-side DPI shim or a debug bus sits downstream.

Parameters:
- NUM_BINS, 14, number of coverage bins presented on cnt_flat (minimum 1).
- CNT_W, 32, width of each bin counter.
- IDX_W, $clog2(NUM_BINS) (minimum 1), width of out_idx.
- TOT_W, $clog2(NUM_BINS+1), width of the totals outputs.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cnt_flat  in  NUM_BINS*CNT_W  counter of bin i at bits [i*CNT_W +: CNT_W].
- binexpr_mask  in  NUM_BINS  bit i = 1 marks bin i as a bin-expression bin.
- start  in  1  single-cycle scan request.
- busy  out  1  high from the cycle after an accepted start until done.
- out_valid  out  1  a stream beat is presented.
- out_ready  in  1  downstream accepts the beat.
- out_idx  out  IDX_W  bin index of the beat.
- out_count  out  CNT_W  snapshotted counter value.
- out_covered  out  1  out_count >= 1.
- out_last  out  1  beat is bin NUM_BINS-1.
- done  out  1  one-cycle pulse after the last beat is accepted.
- total_covered  out  TOT_W  number of covered bins in the last completed scan.
- total_binexpr_covered  out  TOT_W  covered bins that have their mask bit set.
- cov_clear  out  1  clear pulse to the instrumented counters (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; snapshot registers 0; totals 0.
- FSM states: IDLE, SNAP, STREAM, FINISH.
- IDLE -> SNAP on start == 1. busy rises next cycle.
- start while busy is ignored: no queuing, no restart.
- SNAP, one cycle:
  - Registers all NUM_BINS counters and binexpr_mask into the snapshot.
  - Clears the running accumulators.
  - Sets idx = 0. Next state STREAM.
- STREAM:
  - out_valid = 1. out_idx, out_count, out_covered and out_last are driven from snapshot[idx].
  - All beat fields are held stable while out_valid && !out_ready.
  - A beat is accepted on out_valid && out_ready. On acceptance, running_cov += covered and running_bx += covered & mask[idx].
  - On an accepted non-last beat, idx increments.
  - On an accepted last beat, the FSM goes to FINISH. out_valid drops the following cycle.
- Latency: first beat is valid 2 cycles after start is sampled. With out_ready held high, a full scan takes NUM_BINS beats on consecutive cycles.
- FINISH, one cycle:
  - Copies the running accumulators to total_covered and total_binexpr_covered.
  - done = 1, busy = 0 at this edge. Next state IDLE.
- Totals hold until the next FINISH. They are not cleared by start.
- Arithmetic:
  - Covered means the count is non-zero (unsigned compare).
  - Accumulators are TOT_W wide and cannot overflow by construction.
- Counter changes on cnt_flat after SNAP do not affect the scan in progress.
- NUM_BINS == 1: the first beat has out_last = 1.
- reset asserted mid-scan: immediate return to IDLE, all outputs 0, partial totals discarded. No done pulse and no cov_clear.

Optional Feature:
- Macro: COV_READER_CLEAR_EN.
- Defined: cov_clear pulses for exactly one cycle, coincident with done. Downstream zeroes its counters on this pulse (read-and-clear semantics).
- Not defined: cov_clear is tied to 0, no extra logic is generated, and counters are preserved across scans.

Test Plan:
- Reset mid-scan: NUM_BINS=14, counts = i for bin i, out_ready=1, start -> beats idx 0..13 with out_count = i; out_covered = 0 only at idx 0; total_covered = 13; done one cycle after the idx 13 beat. Assert reset at idx 5 of a second scan -> outputs 0 immediately, no done, totals reset to 0.
- Backpressure: mask = 0x3E00 (bins 9..13), bins 9..13 counts {0,3,0,1,7}, others all 1; out_ready toggling 1,0,0,1 -> beat fields stable across stall cycles; total_covered = 12, total_binexpr_covered = 3.
- Snapshot stability: change cnt_flat every cycle during STREAM -> streamed values equal the values present at the SNAP cycle.
- Start while busy: pulse start again at the 3rd beat -> ignored; exactly 14 beats and one done pulse.
- NUM_BINS=1, count 0 -> single beat with out_last=1, out_covered=0; total_covered=0.
- Clear feature: with COV_READER_CLEAR_EN, cov_clear is high exactly on the done cycle. Without it, cov_clear stays 0 for the whole run.

Source files
------------

// File: rtl/cov_count_reader.sv
// Coverage counter readout: snapshots all bin counters on start and streams them one bin per beat.
// Optional macro COV_READER_CLEAR_EN drives cov_clear together with done (read-and-clear).
module cov_count_reader #(
    parameter int NUM_BINS = 14,
    parameter int CNT_W    = 32,
    parameter int IDX_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1,
    parameter int TOT_W    = $clog2(NUM_BINS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_BINS*CNT_W-1:0] cnt_flat,
    input  logic [NUM_BINS-1:0]       binexpr_mask,
    input  logic                      start,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_idx,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_covered,
    output logic                      out_last,
    output logic                      done,
    output logic [TOT_W-1:0]          total_covered,
    output logic [TOT_W-1:0]          total_binexpr_covered,
    output logic                      cov_clear
);

    typedef enum logic [1:0] {IDLE, SNAP, STREAM, FINISH} state_t;

    state_t                             state_reg, state_next;
    logic [NUM_BINS-1:0][CNT_W-1:0]     snap_reg;
    logic [NUM_BINS-1:0]                mask_reg;
    logic [IDX_W-1:0]                   idx_reg;
    logic [TOT_W-1:0]                   run_cov_reg, run_bx_reg;
    logic [TOT_W-1:0]                   tot_cov_reg, tot_bx_reg;

    logic [CNT_W-1:0]                   beat_count;
    logic                               beat_mask;
    logic                               beat_covered;
    logic                               beat_last;
    logic                               beat_accept;
    logic [TOT_W-1:0]                   cov_inc, bx_inc;

    // A one-bin build has no meaningful index, so it reads entry 0 directly.
    generate
        if (NUM_BINS == 1) begin : g_one_bin
            assign beat_count = snap_reg[0];
            assign beat_mask  = mask_reg[0];
        end else begin : g_multi_bin
            assign beat_count = snap_reg[idx_reg];
            assign beat_mask  = mask_reg[idx_reg];
        end
    endgenerate

    assign beat_covered = (beat_count != '0);
    assign beat_last    = (idx_reg == IDX_W'(NUM_BINS - 1));
    assign beat_accept  = (state_reg == STREAM) && out_ready;
    assign cov_inc      = run_cov_reg + TOT_W'(beat_covered);
    assign bx_inc       = run_bx_reg + TOT_W'(beat_covered & beat_mask);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SNAP;
            SNAP:    state_next = STREAM;
            STREAM:  if (beat_accept && beat_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_reg    <= '0;
            mask_reg    <= '0;
            idx_reg     <= '0;
            run_cov_reg <= '0;
            run_bx_reg  <= '0;
            tot_cov_reg <= '0;
            tot_bx_reg  <= '0;
        end else begin
            case (state_reg)
                SNAP: begin
                    snap_reg    <= cnt_flat;
                    mask_reg    <= binexpr_mask;
                    idx_reg     <= '0;
                    run_cov_reg <= '0;
                    run_bx_reg  <= '0;
                end
                STREAM: begin
                    if (beat_accept) begin
                        run_cov_reg <= cov_inc;
                        run_bx_reg  <= bx_inc;
                        // Totals include the last beat so they are valid in the done cycle.
                        if (beat_last) begin
                            tot_cov_reg <= cov_inc;
                            tot_bx_reg  <= bx_inc;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid             = (state_reg == STREAM);
    assign out_idx               = out_valid ? idx_reg : '0;
    assign out_count             = out_valid ? beat_count : '0;
    assign out_covered           = out_valid & beat_covered;
    assign out_last              = out_valid & beat_last;
    assign busy                  = (state_reg == SNAP) || (state_reg == STREAM);
    assign done                  = (state_reg == FINISH);
    assign total_covered         = tot_cov_reg;
    assign total_binexpr_covered = tot_bx_reg;

`ifdef COV_READER_CLEAR_EN
    assign cov_clear = done;
`else
    assign cov_clear = 1'b0;
`endif

endmodule

// File: tb/tb_cov_count_reader.sv
// Scoreboard bench for cov_count_reader: stimulus queues expected beats/totals, a negedge monitor checks them.
module tb_cov_count_reader;

    localparam int NB = 14;
    localparam int CW = 32;
`ifdef COV_READER_CLEAR_EN
    localparam logic CLR_EN = 1'b1;
`else
    localparam logic CLR_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NB*CW-1:0]  cnt_flat = '0;
    logic [NB-1:0]     binexpr_mask = '0;
    logic              start = 1'b0;
    logic              busy, out_valid, out_covered, out_last, done, cov_clear;
    logic              out_ready = 1'b1;
    logic [3:0]        out_idx;
    logic [CW-1:0]     out_count;
    logic [3:0]        total_covered, total_binexpr_covered;

    logic [CW-1:0]     cnt1 = '0;
    logic [0:0]        mask1 = '0;
    logic              start1 = 1'b0, ready1 = 1'b1;
    logic              busy1, valid1, cov1, last1, done1, clr1;
    logic [0:0]        idx1;
    logic [CW-1:0]     count1;
    logic [0:0]        tc1, tbx1;

    always #5 clock = ~clock;

    cov_count_reader #(.NUM_BINS(NB), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .cnt_flat(cnt_flat), .binexpr_mask(binexpr_mask),
        .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_count(out_count), .out_covered(out_covered),
        .out_last(out_last), .done(done), .total_covered(total_covered),
        .total_binexpr_covered(total_binexpr_covered), .cov_clear(cov_clear)
    );

    cov_count_reader #(.NUM_BINS(1), .CNT_W(CW)) dut1 (
        .clock(clock), .reset(reset), .cnt_flat(cnt1), .binexpr_mask(mask1),
        .start(start1), .busy(busy1), .out_valid(valid1), .out_ready(ready1),
        .out_idx(idx1), .out_count(count1), .out_covered(cov1),
        .out_last(last1), .done(done1), .total_covered(tc1),
        .total_binexpr_covered(tbx1), .cov_clear(clr1)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] cnt;
        logic        cov;
        logic        last;
    } beat_t;
    typedef struct packed {
        logic [3:0] tc;
        logic [3:0] bx;
    } tot_t;

    beat_t exp_q[$];
    tot_t  tot_q[$];
    int    errors = 0;
    int    checks = 0;
    int    beats_seen = 0;
    int    done_seen = 0;
    logic  bkp_mode = 1'b0;
    logic [3:0] ready_pat = 4'b1001;
    int    ready_ph = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
    always @(posedge clock) begin
        #1;
        if (bkp_mode) begin
            out_ready = ready_pat[ready_ph];
            ready_ph  = (ready_ph + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    beat_t held;
    logic  held_v = 1'b0;
    logic  pend_done = 1'b0;
    beat_t e;
    tot_t  t;

    always @(negedge clock) begin
        if (reset) begin
            held_v    = 1'b0;
            pend_done = 1'b0;
        end else begin
            if (pend_done) chk("done_after_last", done, 1'b1);
            pend_done = 1'b0;
            if (held_v) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_fields", {out_idx, out_count, out_covered, out_last}, held);
            end
            if (out_valid && out_ready) begin
                beats_seen++;
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got idx %0d expected none", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_idx", out_idx, e.idx);
                    chk("beat_count", out_count, e.cnt);
                    chk("beat_covered", out_covered, e.cov);
                    chk("beat_last", out_last, e.last);
                    if (e.last) pend_done = 1'b1;
                end
            end else if (out_valid) begin
                held_v = 1'b1;
                held   = {out_idx, out_count, out_covered, out_last};
            end else begin
                held_v = 1'b0;
            end
            if (done) begin
                done_seen++;
                chk("busy_at_done", busy, 1'b0);
                chk("cov_clear_at_done", cov_clear, CLR_EN);
                if (tot_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    t = tot_q.pop_front();
                    chk("totals", {total_covered, total_binexpr_covered}, {t.tc, t.bx});
                end
            end else if (cov_clear) begin
                checks++;
                errors++;
                $display("FAIL cov_clear_stray: got 1 expected 0");
            end
        end
    end

    task automatic do_scan(input logic [NB*CW-1:0] flat, input logic [NB-1:0] mask,
                           input int etc, input int ebx, input logic [7:0] prev_tot,
                           input bit scramble, input bit restart, input int reset_at);
        int d0, b0, n;
        logic [CW-1:0] c;
        @(posedge clock); #1;
        cnt_flat     = flat;
        binexpr_mask = mask;
        n = (reset_at >= 0) ? reset_at : NB;
        for (int i = 0; i < n; i++) begin
            c = flat[i*CW +: CW];
            exp_q.push_back('{idx: 4'(i), cnt: c, cov: (c != 0), last: (i == NB - 1)});
        end
        if (reset_at < 0) tot_q.push_back('{tc: 4'(etc), bx: 4'(ebx)});
        d0 = done_seen;
        b0 = beats_seen;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("valid_in_snap", out_valid, 1'b0);
        chk("totals_held_on_start", {total_covered, total_binexpr_covered}, prev_tot);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 0) chk("first_beat_latency", {out_valid, out_idx}, {1'b1, 4'd0});
            if (scramble)
                for (int k = 0; k < NB; k++) cnt_flat[k*CW +: CW] = $urandom();
            if (restart) start = out_valid && (out_idx == 4'd2);
            if (reset_at >= 0 && out_valid && out_idx == 4'(reset_at)) begin
                reset = 1'b1;
                #1;
                chk("reset_outputs", {out_valid, busy, done, out_idx, out_count, out_covered,
                    out_last, total_covered, total_binexpr_covered, cov_clear}, 64'd0);
                break;
            end
            if (done_seen != d0) break;
        end
        start = 1'b0;
        if (reset_at >= 0) begin
            @(posedge clock); #1;
            reset = 1'b0;
        end
        repeat (20) @(posedge clock);
        #1;
        chk("done_pulses", done_seen - d0, (reset_at >= 0) ? 0 : 1);
        chk("beat_total", beats_seen - b0, n);
        chk("queue_drained", exp_q.size() + tot_q.size(), 0);
        chk("totals_hold", {total_covered, total_binexpr_covered},
            (reset_at >= 0) ? 8'd0 : {4'(etc), 4'(ebx)});
        exp_q.delete();
        tot_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [NB*CW-1:0] f_ramp, f_bkp, f_snap;

    initial begin
        for (int i = 0; i < NB; i++) begin
            f_ramp[i*CW +: CW] = 32'(i);
            f_bkp[i*CW +: CW]  = 32'd1;
            f_snap[i*CW +: CW] = (i % 3 == 0) ? 32'd0 : (32'h8000_0000 + 32'(i));
        end
        f_bkp[9*CW +: CW]  = 32'd0;
        f_bkp[10*CW +: CW] = 32'd3;
        f_bkp[11*CW +: CW] = 32'd0;
        f_bkp[12*CW +: CW] = 32'd1;
        f_bkp[13*CW +: CW] = 32'd7;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", {out_valid, busy, done, out_idx, out_count, out_covered,
            out_last, total_covered, total_binexpr_covered, cov_clear}, 64'd0);
        reset = 1'b0;

        // Ramp counts: bin 0 is the only uncovered bin.
        do_scan(f_ramp, 14'h00FF, 13, 7, 8'h00, 1'b0, 1'b0, -1);
        // Reset at beat 5 of a second scan discards everything.
        do_scan(f_ramp, 14'h00FF, 0, 0, 8'hD7, 1'b0, 1'b0, 5);
        // Backpressure with 1,0,0,1 ready pattern.
        bkp_mode = 1'b1;
        do_scan(f_bkp, 14'h3E00, 12, 3, 8'h00, 1'b0, 1'b0, -1);
        bkp_mode = 1'b0;
        // Inputs scrambled every cycle after the snapshot.
        do_scan(f_snap, 14'h3FFF, 9, 9, 8'hC3, 1'b1, 1'b0, -1);
        // Start pulsed again at the third beat must be ignored.
        do_scan(f_ramp, 14'h2001, 13, 1, 8'h99, 1'b0, 1'b1, -1);

        // Single-bin instance: count 0, then count 5.
        for (int r = 0; r < 2; r++) begin
            @(posedge clock); #1;
            cnt1   = (r == 0) ? 32'd0 : 32'd5;
            mask1  = 1'b1;
            start1 = 1'b1;
            @(posedge clock); #1;
            start1 = 1'b0;
            chk("nb1_busy", busy1, 1'b1);
            @(posedge clock); #1;
            chk("nb1_beat", {valid1, idx1, count1, cov1, last1},
                {1'b1, 1'b0, cnt1, (r == 1), 1'b1});
            @(posedge clock); #1;
            chk("nb1_done", {done1, valid1, busy1, clr1}, {1'b1, 1'b0, 1'b0, CLR_EN});
            chk("nb1_totals", {tc1, tbx1}, (r == 0) ? 2'b00 : 2'b11);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
